// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_ctrl
//  Description : Raster-scan control for an N x N convolution window. Tracks
//                the row/column of incoming pixels, enables the line buffers,
//                and flags each fully-populated window with its top-left
//                coordinate.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int N          = 3,
    parameter int CW         = $clog2((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_pix_valid,
    output logic          o_shift_en,
    output logic          o_win_valid,
    output logic [CW-1:0] o_win_row,
    output logic [CW-1:0] o_win_col,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_last_col = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] c_last_row = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_nm1      = CW'(N - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_win_valid;
    logic [CW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;

    logic w_active;
    logic w_accept;
    logic w_frame_go;
    logic w_last_pix;
    logic w_win_hit;

    // Abort wins over a pixel in the same cycle so nothing is shifted in.
    assign w_active   = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_accept   = w_active && i_pix_valid && !i_abort;
    assign w_frame_go = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_last_pix = (r_row == c_last_row) && (r_col == c_last_col);
    // Requiring col >= N-1 keeps windows from straddling a line wrap.
    assign w_win_hit  = (r_row >= c_nm1) && (r_col >= c_nm1);

    assign o_shift_en  = w_accept;
    assign o_busy      = w_active;
    assign o_done      = (r_state == S_DONE);
    assign o_win_valid = r_win_valid;
    assign o_win_row   = r_win_row;
    assign o_win_col   = r_win_col;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: frame start, fill-to-run, end of frame, abort.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_frame_go) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL, S_RUN: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_accept) begin
                    if (w_last_pix) begin
                        w_next_state = S_DONE;
                    end else if ((r_state == S_FILL) && (r_row == c_nm1) && (r_col == '0)) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Raster position of the next pixel; cleared at frame start, held on gaps.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_frame_go) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_last_col) begin
                r_col <= '0;
                r_row <= r_row + c_one;
            end else begin
                r_col <= r_col + c_one;
            end
        end
    end

    // Window flag and top-left coordinate, one cycle after the completing pixel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
            r_win_valid <= w_accept && w_win_hit;
            if (w_accept && w_win_hit) begin
                r_win_row <= r_row - c_nm1;
                r_win_col <= r_col - c_nm1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_ctrl
//  Description : Directed self-checking bench for conv_window_ctrl on a
//                5 x 4 image with a 3 x 3 window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int NN = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic          i_pix_valid;
    logic          o_shift_en;
    logic          o_win_valid;
    logic [CW-1:0] o_win_row;
    logic [CW-1:0] o_win_col;
    logic          o_busy;
    logic          o_done;

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .N         (NN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_pix_valid(i_pix_valid),
        .o_shift_en (o_shift_en),
        .o_win_valid(o_win_valid),
        .o_win_row  (o_win_row),
        .o_win_col  (o_win_col),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Mid-cycle event log: window coordinates, done pulses, shift enables.
    logic [5:0] win_q[$];
    int         done_cnt = 0;
    int         sh_cnt   = 0;

    always @(negedge clk) begin
        if (o_win_valid) win_q.push_back({o_win_row, o_win_col});
        if (o_done)      done_cnt++;
        if (o_shift_en)  sh_cnt++;
    end

    // Expected window order for a full frame, {row,col} as two octal digits.
    logic [5:0] exp_win[6] = '{6'o00, 6'o01, 6'o02, 6'o10, 6'o11, 6'o12};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
    endtask

    // Present raster pixel k for one cycle; optionally check the window result.
    task automatic pixel(input int k, input bit chk);
        int r;
        int c;
        bit e;
        r = k / W;
        c = k % W;
        e = (r >= NN - 1) && (c >= NN - 1);
        i_pix_valid = 1'b1;
        #1;
        check("shift_en_on_pixel", {31'd0, o_shift_en}, 32'd1);
        @(posedge clk);
        #1;
        i_pix_valid = 1'b0;
        if (chk) begin
            check($sformatf("win_valid_px%0d", k), {31'd0, o_win_valid}, {31'd0, e});
            if (e) begin
                check($sformatf("win_row_px%0d", k), {29'd0, o_win_row}, r - (NN - 1));
                check($sformatf("win_col_px%0d", k), {29'd0, o_win_col}, c - (NN - 1));
            end
        end
    endtask

    task automatic check_windows(input string tag, input int base);
        check({tag, "_win_count"}, win_q.size() - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < win_q.size()) begin
                check($sformatf("%s_win%0d", tag, i), {26'd0, win_q[base + i]}, {26'd0, exp_win[i]});
            end
        end
    endtask

    initial begin
        int base;
        int base2;
        int d0;
        int s0;

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_pix_valid = 1'b1;
        tick();
        tick();
        // Reset state, with a pixel offered while idle.
        check("rst_busy",      {31'd0, o_busy},      32'd0);
        check("rst_done",      {31'd0, o_done},      32'd0);
        check("rst_win_valid", {31'd0, o_win_valid}, 32'd0);
        check("rst_shift_en",  {31'd0, o_shift_en},  32'd0);
        check("rst_win_row",   {29'd0, o_win_row},   32'd0);
        check("rst_win_col",   {29'd0, o_win_col},   32'd0);
        i_rst       = 1'b0;
        i_pix_valid = 1'b0;
        tick();

        // Full frame, back-to-back pixels.
        base = win_q.size();
        d0   = done_cnt;
        start_frame();
        for (int k = 0; k < W * H; k++) pixel(k, 1'b1);
        check("full_done_with_last_win", {31'd0, o_done}, 32'd1);
        check("full_busy_in_done",       {31'd0, o_busy}, 32'd0);
        tick();
        check("full_done_one_cycle", {31'd0, o_done},      32'd0);
        check("full_busy_after",     {31'd0, o_busy},      32'd0);
        check("full_win_after",      {31'd0, o_win_valid}, 32'd0);
        check("full_done_count",     done_cnt - d0,        32'd1);
        check_windows("full", base);

        // Gapped input: one idle cycle after each pixel.
        base = win_q.size();
        d0   = done_cnt;
        s0   = sh_cnt;
        start_frame();
        for (int k = 0; k < W * H; k++) begin
            pixel(k, 1'b0);
            tick();
        end
        check("gap_shift_count", sh_cnt - s0,   32'd20);
        check("gap_done_count",  done_cnt - d0, 32'd1);
        check_windows("gap", base);

        // Abort after pixel 12; the pixel offered with abort would complete (0,0).
        base = win_q.size();
        d0   = done_cnt;
        start_frame();
        for (int k = 0; k < 12; k++) pixel(k, 1'b1);
        i_pix_valid = 1'b1;
        i_abort     = 1'b1;
        #1;
        check("abort_shift_en", {31'd0, o_shift_en}, 32'd0);
        tick();
        i_abort     = 1'b0;
        i_pix_valid = 1'b0;
        check("abort_busy",      {31'd0, o_busy},      32'd0);
        check("abort_win_valid", {31'd0, o_win_valid}, 32'd0);
        tick();
        check("abort_no_done",   done_cnt - d0,        32'd0);
        check("abort_no_window", win_q.size() - base,  32'd0);
        base2 = win_q.size();
        start_frame();
        for (int k = 0; k < W * H; k++) pixel(k, 1'b1);
        tick();
        check_windows("after_abort", base2);

        // Reset after pixel 15 (last visible window was (0,2)).
        start_frame();
        for (int k = 0; k < 15; k++) pixel(k, 1'b1);
        i_pix_valid = 1'b1;
        i_rst       = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mrst_win_valid", {31'd0, o_win_valid}, 32'd0);
        check("mrst_win_row",   {29'd0, o_win_row},   32'd0);
        check("mrst_win_col",   {29'd0, o_win_col},   32'd0);
        check("mrst_done",      {31'd0, o_done},      32'd0);
        check("mrst_busy",      {31'd0, o_busy},      32'd0);
        for (int i = 0; i < 3; i++) begin
            check("mrst_shift_en_idle", {31'd0, o_shift_en}, 32'd0);
            tick();
        end
        i_pix_valid = 1'b0;
        base2 = win_q.size();
        start_frame();
        for (int k = 0; k < W * H; k++) pixel(k, 1'b1);
        tick();
        check_windows("after_rst", base2);

        // Ignored inputs: start during RUN, pixel and start during DONE.
        base = win_q.size();
        d0   = done_cnt;
        start_frame();
        for (int k = 0; k < 11; k++) pixel(k, 1'b1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("ign_busy_run", {31'd0, o_busy}, 32'd1);
        for (int k = 11; k < W * H; k++) pixel(k, 1'b1);
        i_pix_valid = 1'b1;
        i_start     = 1'b1;
        #1;
        check("ign_done",     {31'd0, o_done},     32'd1);
        check("ign_shift_en", {31'd0, o_shift_en}, 32'd0);
        tick();
        i_pix_valid = 1'b0;
        i_start     = 1'b0;
        check("ign_busy_after",  {31'd0, o_busy},      32'd0);
        check("ign_win_after",   {31'd0, o_win_valid}, 32'd0);
        tick();
        check("ign_done_count",  done_cnt - d0,        32'd1);
        check_windows("ign", base);

        // Abort and start together in IDLE: stay idle.
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        check("abort_start_idle", {31'd0, o_busy}, 32'd0);
        i_pix_valid = 1'b1;
        #1;
        check("abort_start_shift", {31'd0, o_shift_en}, 32'd0);
        i_pix_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
